haraka_s_sched: RTL and testbench
=================================

Name: haraka_s_sched

Overview:
- Round sequencer for the Haraka-S permutation core (mux → two AES layers → 512-bit mix → demux).
- Accepts one 512-bit state over a valid/ready handshake and drives the core's select line for ROUNDS passes.
- Samples the core result at the end of each pass and presents the final state on a valid/ready output.
- Sits between the sponge/absorb logic and the core; one permutation in flight at a time.

Parameters:
- ROUNDS, 5, core passes per permutation (each pass = 2 AES rounds + mix); legal 1..15.
- PASS_LAT, 2, clock cycles from core input change to valid mix output; legal 1..15.
- IDX_W, 4, width of round and pass counters; must satisfy 2**IDX_W > max(ROUNDS, PASS_LAT).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns to IDLE.
- in_valid  in  1  input state offered.
- in_ready  out  1  scheduler can accept.
- in_data  in  512  input state.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  512  permuted state.
- core_in  out  512  registered copy of the accepted state, to core input a.
- core_sel  out  1  0 = core takes core_in; 1 = core takes its feedback.
- core_res  in  512  core mix output.
- rnd_idx  out  IDX_W  current round (0..ROUNDS-1), used for round-constant lookup.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n; asserting it aborts any operation. Reset values:
  - state = IDLE.
  - in_ready = 1; out_valid, core_sel, busy, rnd_idx, pass counter = 0.
  - core_in = 0; out_data = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = !flush.
  - Accept on in_valid && in_ready: in_data → core_in; rnd_idx = 0; pass_cnt = 0; go to RUN.
- RUN:
  - core_sel = (rnd_idx != 0).
  - pass_cnt counts 0..PASS_LAT-1.
  - When pass_cnt == PASS_LAT-1: core_res is sampled into a result register and pass_cnt wraps to 0.
    - If rnd_idx == ROUNDS-1: go to DONE.
    - Otherwise rnd_idx increments.
  - in_ready = 0.
- DONE:
  - out_valid = 1; out_data holds the result register and stays stable until the handshake.
  - On out_valid && out_ready: go to IDLE; out_valid drops the next cycle.
  - out_data keeps its last value after the handshake.
- Latency: accept at edge T → out_valid high from edge T + ROUNDS*PASS_LAT. With defaults this is 10 cycles.
- Throughput: one permutation per ROUNDS*PASS_LAT + 2 cycles when out_ready is held high. No back-to-back overlap.
- Flush, in any state: next state is IDLE; out_valid = 0; counters = 0; result discarded.
  - Flush in IDLE with in_valid high: no accept.
  - Flush in DONE with out_ready high: no handshake counted.
- ROUNDS = 1: core_sel stays 0 for the whole operation.
- rnd_idx holds ROUNDS-1 in DONE and is cleared on entering IDLE.

Optional Feature:
- Macro: HARAKA_FEEDFWD_EN.
- Defined: out_data = final core_res XOR the accepted input, i.e. Haraka512 feed-forward. The accepted input is kept in core_in, which is not modified during RUN/DONE.
- Undefined: out_data = final core_res unmodified. No XOR logic is present.

Test Plan:
- Core stub returns core_in+1 when sel=0, else previous+1; accept 0x0 at T, out_ready=1 → out_valid at T+10, out_data=0x5, core_sel pattern 0,0,1×8, rnd_idx 0..4.
- Same as above with HARAKA_FEEDFWD_EN and in_data=0xF0 → out_data = 0xF5 ^ 0xF0 = 0x05.
- out_ready held low 7 cycles in DONE → out_valid and out_data stable; in_ready=0 throughout; handshake on cycle 8 → IDLE, in_ready=1 next cycle.
- flush pulsed at cycle 4 of RUN → IDLE next cycle, out_valid never rises; a new accept produces the correct result at +10.
- rst_n asserted asynchronously mid-RUN (between edges) → outputs reach reset values immediately; no out_valid after release.
- in_valid and flush both high in IDLE → no accept, in_ready=0 that cycle; accept happens on the next cycle with flush low.

Source files
------------

// File: rtl/haraka_s_sched.sv
// Round sequencer for the Haraka-S permutation core: accepts one state, steps the core
// through ROUNDS passes and returns the result. Optional feed-forward: HARAKA_FEEDFWD_EN.
module haraka_s_sched #(
    parameter int ROUNDS   = 5,
    parameter int PASS_LAT = 2,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [511:0]     out_data,
    output logic [511:0]     core_in,
    output logic             core_sel,
    input  logic [511:0]     core_res,
    output logic [IDX_W-1:0] rnd_idx,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] PASS_MAX = IDX_W'(PASS_LAT - 1);
    localparam logic [IDX_W-1:0] RND_MAX  = IDX_W'(ROUNDS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] pass_cnt;
    logic             pass_last;
    logic             rnd_last;
    logic [511:0]     final_res;

    assign pass_last = (pass_cnt == PASS_MAX);
    assign rnd_last  = (rnd_idx == RND_MAX);

    // core_in is never touched after the accept, so it still holds the input for feed-forward
`ifdef HARAKA_FEEDFWD_EN
    assign final_res = core_res ^ core_in;
`else
    assign final_res = core_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pass_cnt <= '0;
            rnd_idx  <= '0;
            core_in  <= '0;
            out_data <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                pass_cnt <= '0;
                rnd_idx  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (in_valid) begin
                            core_in  <= in_data;
                            pass_cnt <= '0;
                            rnd_idx  <= '0;
                        end
                    end
                    RUN: begin
                        if (pass_last) begin
                            pass_cnt <= '0;
                            if (rnd_last) begin
                                out_data <= final_res;
                            end else begin
                                rnd_idx <= rnd_idx + IDX_W'(1);
                            end
                        end else begin
                            pass_cnt <= pass_cnt + IDX_W'(1);
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            rnd_idx <= '0;
                        end
                    end
                    default: begin
                        pass_cnt <= '0;
                        rnd_idx  <= '0;
                    end
                endcase
            end
        end
    end

    // out_valid is masked by flush so a flush in DONE can never complete a handshake
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_sel  = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                in_ready = !flush;
                if (in_valid && !flush) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                core_sel = (rnd_idx != '0);
                if (pass_last && rnd_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = !flush;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_haraka_s_sched.sv
// Self-checking bench for haraka_s_sched: stub core adds 1 per pass, reference model
// predicts result = input + ROUNDS (XOR input when HARAKA_FEEDFWD_EN is defined).
module tb_haraka_s_sched;

    localparam int ROUNDS   = 5;
    localparam int PASS_LAT = 2;
    localparam int IDX_W    = 4;
    localparam int RUN_LEN  = ROUNDS * PASS_LAT;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [511:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [511:0]     out_data;
    logic [511:0]     core_in;
    logic             core_sel;
    logic [511:0]     core_res;
    logic [IDX_W-1:0] rnd_idx;
    logic             busy;

    int               test_cnt;
    int               fail_cnt;
    int               stub_cnt;
    logic [511:0]     stub_fb;

    haraka_s_sched #(
        .ROUNDS  (ROUNDS),
        .PASS_LAT(PASS_LAT),
        .IDX_W   (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .core_in  (core_in),
        .core_sel (core_sel),
        .core_res (core_res),
        .rnd_idx  (rnd_idx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core: one pass adds 1, feedback is the result latched at the end of each pass
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= 0;
            stub_fb  <= '0;
        end else if (!busy) begin
            stub_cnt <= 0;
        end else if (stub_cnt == PASS_LAT - 1) begin
            stub_cnt <= 0;
            stub_fb  <= core_res;
        end else begin
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign core_res = (core_sel ? stub_fb : core_in) + 512'd1;

    function automatic logic [511:0] modelResult(input logic [511:0] d);
        logic [511:0] r;
        r = d + 512'(ROUNDS);
`ifdef HARAKA_FEEDFWD_EN
        r = r ^ d;
`endif
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        test_cnt++;
        assert (observed === expected)
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checkOutput(tag, 512'(observed), 512'(expected));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offers one state at a negedge and returns at the negedge after the accepting edge
    task automatic applyStimulus(input logic [511:0] data);
        in_valid = 1'b1;
        in_data  = data;
        #1;
        checkBit("in_ready_before_accept", in_ready, 1'b1);
        stepCycle();
        in_valid = 1'b0;
    endtask

    // Walks the RUN phase, holds out_ready low for 'hold' cycles in DONE, then hands off
    task automatic runCheck(input logic [511:0] data, input int hold);
        logic [511:0] exp_res;
        exp_res = modelResult(data);
        for (int k = 0; k < RUN_LEN; k++) begin
            #1;
            checkOutput("run_rnd_idx", 512'(rnd_idx), 512'(k / PASS_LAT));
            checkBit("run_core_sel", core_sel, (k / PASS_LAT) != 0);
            checkBit("run_out_valid", out_valid, 1'b0);
            checkBit("run_in_ready", in_ready, 1'b0);
            checkBit("run_busy", busy, 1'b1);
            checkOutput("run_core_in", core_in, data);
            stepCycle();
        end
        for (int h = 0; h < hold; h++) begin
            #1;
            checkBit("done_out_valid", out_valid, 1'b1);
            checkOutput("done_out_data", out_data, exp_res);
            checkBit("done_in_ready", in_ready, 1'b0);
            checkOutput("done_rnd_idx", 512'(rnd_idx), 512'(ROUNDS - 1));
            stepCycle();
        end
        out_ready = 1'b1;
        #1;
        checkBit("handshake_out_valid", out_valid, 1'b1);
        checkOutput("handshake_out_data", out_data, exp_res);
        stepCycle();
        out_ready = 1'b0;
        #1;
        checkBit("after_out_valid", out_valid, 1'b0);
        checkBit("after_in_ready", in_ready, 1'b1);
        checkBit("after_busy", busy, 1'b0);
        checkOutput("after_rnd_idx", 512'(rnd_idx), 512'(0));
        checkOutput("after_out_data", out_data, exp_res);
    endtask

    task automatic runPerm(input logic [511:0] data, input int hold);
        applyStimulus(data);
        runCheck(data, hold);
    endtask

    initial begin
        logic [511:0] d;
        test_cnt  = 0;
        fail_cnt  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #3;
        checkBit("reset_in_ready", in_ready, 1'b1);
        checkBit("reset_out_valid", out_valid, 1'b0);
        checkBit("reset_core_sel", core_sel, 1'b0);
        checkBit("reset_busy", busy, 1'b0);
        checkOutput("reset_rnd_idx", 512'(rnd_idx), 512'(0));
        checkOutput("reset_out_data", out_data, 512'(0));
        checkOutput("reset_core_in", core_in, 512'(0));
        @(negedge clk);
        rst_n = 1'b1;

        runPerm(512'h0, 0);
        checkOutput("directed_zero_result", out_data, 512'h5);
        runPerm(512'hF0, 0);
`ifdef HARAKA_FEEDFWD_EN
        checkOutput("directed_f0_result", out_data, 512'h05);
`else
        checkOutput("directed_f0_result", out_data, 512'hF5);
`endif

        runPerm(rand512(), 7);

        // Flush on the fifth RUN cycle aborts the permutation
        applyStimulus(rand512());
        repeat (4) stepCycle();
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        #1;
        checkBit("flush_busy", busy, 1'b0);
        checkBit("flush_in_ready", in_ready, 1'b1);
        checkOutput("flush_rnd_idx", 512'(rnd_idx), 512'(0));
        for (int i = 0; i < RUN_LEN + 2; i++) begin
            #1;
            checkBit("flush_no_out_valid", out_valid, 1'b0);
            stepCycle();
        end
        runPerm(rand512(), 1);

        // Asynchronous reset between edges in the middle of RUN
        d = rand512();
        applyStimulus(d);
        repeat (3) stepCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("areset_busy", busy, 1'b0);
        checkBit("areset_in_ready", in_ready, 1'b1);
        checkBit("areset_core_sel", core_sel, 1'b0);
        checkOutput("areset_rnd_idx", 512'(rnd_idx), 512'(0));
        checkOutput("areset_core_in", core_in, 512'(0));
        checkOutput("areset_out_data", out_data, 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < RUN_LEN + 3; i++) begin
            #1;
            checkBit("areset_no_out_valid", out_valid, 1'b0);
            checkBit("areset_idle", busy, 1'b0);
            stepCycle();
        end

        // in_valid together with flush in IDLE must not be accepted
        d = rand512();
        in_valid = 1'b1;
        in_data  = d;
        flush    = 1'b1;
        #1;
        checkBit("flush_idle_in_ready", in_ready, 1'b0);
        stepCycle();
        flush = 1'b0;
        #1;
        checkBit("flush_idle_no_accept", busy, 1'b0);
        checkBit("flush_idle_ready_back", in_ready, 1'b1);
        stepCycle();
        in_valid = 1'b0;
        runCheck(d, 2);

        for (int n = 0; n < 6; n++) begin
            runPerm(rand512(), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
